// File: rtl/q_bank_readout.sv
`default_nettype none
// ============================================================================
// Module   : q_bank_readout
// Brief    : Snapshots the Q or Q2 stabilizer bank and streams it row by row
//            over a valid/ready port, optionally dropping identity rows.
// Revision : 1.0  initial release
// ============================================================================
module q_bank_readout #(
   parameter  int NUM_QUBIT  = 4,
   localparam int MAX_VECTOR = 2**NUM_QUBIT
) (
   input  logic                   clk,
   input  logic                   rst_new,
   input  logic                   start,
   input  logic                   select_q2,
   input  logic                   skip_identity,
   input  logic [1:0]             reg_literals_Q  [0:MAX_VECTOR-1][0:NUM_QUBIT-1],
   input  logic                   reg_phase_Q     [0:MAX_VECTOR-1],
   input  logic [1:0]             reg_literals_Q2 [0:MAX_VECTOR-1][0:NUM_QUBIT-1],
   input  logic                   reg_phase_Q2    [0:MAX_VECTOR-1],
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [NUM_QUBIT-1:0]   out_index,
   output logic [2*NUM_QUBIT-1:0] out_literals,
   output logic                   out_phase,
   output logic                   out_last,
   output logic [NUM_QUBIT:0]     out_count,
   output logic                   busy,
   output logic                   done
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_SEND = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]             r_state;
   logic [1:0]             w_next;

   logic [2*NUM_QUBIT-1:0] r_snap_lit [MAX_VECTOR];
   logic                   r_snap_ph  [MAX_VECTOR];
   logic                   r_skip;

   logic [2*NUM_QUBIT-1:0] w_bank_lit [MAX_VECTOR];
   logic                   w_bank_ph  [MAX_VECTOR];
   logic [2*NUM_QUBIT-1:0] w_src_lit  [MAX_VECTOR];
   logic                   w_src_ph   [MAX_VECTOR];
   logic                   w_src_skip;
   logic [MAX_VECTOR-1:0]  w_qual;
   logic [NUM_QUBIT:0]     w_from;
   logic [NUM_QUBIT-1:0]   w_first;
   logic                   w_found;
   logic                   w_more;
   logic                   w_idle;
   logic                   w_hs;

   assign w_idle = (r_state == c_IDLE);
   assign w_hs   = out_valid && out_ready;

   always_comb begin
      for (int i = 0; i < MAX_VECTOR; i++) begin
         w_bank_lit[i] = '0;
         for (int j = 0; j < NUM_QUBIT; j++) begin
            w_bank_lit[i][2*j +: 2] = select_q2 ? reg_literals_Q2[i][j] : reg_literals_Q[i][j];
         end
         w_bank_ph[i] = select_q2 ? reg_phase_Q2[i] : reg_phase_Q[i];
      end
   end

   // In IDLE the search looks at the live bank so the first row is ready the
   // cycle after start; afterwards it only ever sees the snapshot.
   always_comb begin
      w_src_skip = w_idle ? skip_identity : r_skip;
      w_qual     = '0;
      for (int i = 0; i < MAX_VECTOR; i++) begin
         w_src_lit[i] = w_idle ? w_bank_lit[i] : r_snap_lit[i];
         w_src_ph[i]  = w_idle ? w_bank_ph[i]  : r_snap_ph[i];
         w_qual[i]    = !w_src_skip || (w_src_lit[i] != '0) || w_src_ph[i];
      end
   end

   assign w_from = w_idle ? '0 : ({1'b0, out_index} + (NUM_QUBIT+1)'(1));

   always_comb begin
      w_first = '0;
      w_found = 1'b0;
      w_more  = 1'b0;
      for (int i = 0; i < MAX_VECTOR; i++) begin
         if (w_qual[i] && ((NUM_QUBIT+1)'(i) >= w_from)) begin
            if (w_found) begin
               w_more = 1'b1;
            end else begin
               w_first = NUM_QUBIT'(i);
               w_found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_new) r_state <= c_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (start) w_next = w_found ? c_SEND : c_DONE;
         c_SEND:  if (w_hs && out_last) w_next = c_DONE;
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (r_state == c_SEND);
      busy      = (r_state == c_SEND) || (r_state == c_DONE);
      done      = (r_state == c_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst_new) begin
         for (int i = 0; i < MAX_VECTOR; i++) begin
            r_snap_lit[i] <= '0;
            r_snap_ph[i]  <= 1'b0;
         end
         r_skip       <= 1'b0;
         out_index    <= '0;
         out_literals <= '0;
         out_phase    <= 1'b0;
         out_last     <= 1'b0;
         out_count    <= '0;
      end else if (w_idle && start) begin
         for (int i = 0; i < MAX_VECTOR; i++) begin
            r_snap_lit[i] <= w_bank_lit[i];
            r_snap_ph[i]  <= w_bank_ph[i];
         end
         r_skip       <= skip_identity;
         out_count    <= '0;
         out_index    <= w_first;
         out_literals <= w_src_lit[w_first];
         out_phase    <= w_src_ph[w_first];
         out_last     <= !w_more;
      end else if (w_hs) begin
         out_count <= out_count + (NUM_QUBIT+1)'(1);
         if (!out_last) begin
            out_index    <= w_first;
            out_literals <= w_src_lit[w_first];
            out_phase    <= w_src_ph[w_first];
            out_last     <= !w_more;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_q_bank_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_q_bank_readout
// Brief    : Directed and randomized readouts checked against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_q_bank_readout;

   localparam int NQ = 2;
   localparam int MV = 4;
   localparam logic [1:0] c_I = 2'd0, c_X = 2'd1, c_Z = 2'd2, c_Y = 2'd3;

   logic          clk = 1'b0;
   logic          rst_new, start, select_q2, skip_identity, out_ready;
   logic [1:0]    lq  [0:MV-1][0:NQ-1];
   logic          pq  [0:MV-1];
   logic [1:0]    lq2 [0:MV-1][0:NQ-1];
   logic          pq2 [0:MV-1];
   logic          out_valid, out_phase, out_last, busy, done;
   logic [NQ-1:0] out_index;
   logic [2*NQ-1:0] out_literals;
   logic [NQ:0]   out_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   q_bank_readout #(.NUM_QUBIT(NQ)) dut (
      .clk(clk), .rst_new(rst_new), .start(start), .select_q2(select_q2),
      .skip_identity(skip_identity),
      .reg_literals_Q(lq), .reg_phase_Q(pq),
      .reg_literals_Q2(lq2), .reg_phase_Q2(pq2),
      .out_ready(out_ready), .out_valid(out_valid), .out_index(out_index),
      .out_literals(out_literals), .out_phase(out_phase), .out_last(out_last),
      .out_count(out_count), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*NQ-1:0] row_lit(input bit sel, input int r);
      logic [2*NQ-1:0] v;
      for (int c = 0; c < NQ; c++) v[2*c +: 2] = sel ? lq2[r][c] : lq[r][c];
      return v;
   endfunction

   task automatic load_test_bank();
      lq[0][0] = c_X; lq[0][1] = c_X; pq[0] = 1'b0;
      lq[1][0] = c_Z; lq[1][1] = c_I; pq[1] = 1'b1;
      lq[2][0] = c_I; lq[2][1] = c_I; pq[2] = 1'b0;
      lq[3][0] = c_Y; lq[3][1] = c_Z; pq[3] = 1'b0;
   endtask

   task automatic scramble_banks();
      for (int r = 0; r < MV; r++) begin
         bool_ident_row(r);
      end
   endtask

   task automatic bool_ident_row(input int r);
      bit zero_q, zero_q2;
      zero_q  = ($urandom_range(0, 2) == 0);
      zero_q2 = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < NQ; c++) begin
         lq[r][c]  = zero_q  ? c_I : 2'($urandom_range(0, 3));
         lq2[r][c] = zero_q2 ? c_I : 2'($urandom_range(0, 3));
      end
      pq[r]  = zero_q  ? 1'b0 : 1'($urandom_range(0, 1));
      pq2[r] = zero_q2 ? 1'b0 : 1'($urandom_range(0, 1));
   endtask

   // mode: 0 ready always high, 1 ready low 3 cycles on row stall_idx, 2 random ready
   task automatic readout(input bit sel, input bit skp, input int mode, input int stall_idx,
                          input bit mutate, input bit restart);
      logic [2*NQ-1:0] s_lit [MV];
      logic            s_ph  [MV];
      int              exp_q [$];
      int              k = 0;
      int              stall_left = 3;
      bit              fin = 1'b0;
      for (int r = 0; r < MV; r++) begin
         s_lit[r] = row_lit(sel, r);
         s_ph[r]  = sel ? pq2[r] : pq[r];
         if (!skp || s_lit[r] != '0 || s_ph[r]) exp_q.push_back(r);
      end
      start = 1'b1; select_q2 = sel; skip_identity = skp;
      @(posedge clk); #1;
      start = 1'b0; select_q2 = 1'($urandom_range(0, 1)); skip_identity = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 1) begin
            if (k < exp_q.size() && exp_q[k] == stall_idx && stall_left > 0) begin
               out_ready = 1'b0; stall_left--;
            end else out_ready = 1'b1;
         end else out_ready = 1'($urandom_range(0, 1));
         if (mutate) scramble_banks();
         start = restart && (cyc == 1 || k == exp_q.size());
         @(negedge clk);
         if (k < exp_q.size()) begin
            chk("valid", out_valid, 1);
            chk("index", out_index, exp_q[k]);
            chk("literals", out_literals, s_lit[exp_q[k]]);
            chk("phase", out_phase, s_ph[exp_q[k]]);
            chk("last", out_last, (k == exp_q.size() - 1));
            chk("count", out_count, k);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            if (out_ready) k++;
         end else begin
            chk("done_valid", out_valid, 0);
            chk("done", done, 1);
            chk("done_busy", busy, 1);
            chk("final_count", out_count, exp_q.size());
            fin = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk("timeout", fin, 1);
      start = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_valid", out_valid, 0);
      chk("hold_count", out_count, exp_q.size());
      @(posedge clk); #1;
   endtask

   initial begin
      rst_new = 1'b1; start = 1'b0; select_q2 = 1'b0; skip_identity = 1'b0; out_ready = 1'b1;
      for (int r = 0; r < MV; r++) begin
         for (int c = 0; c < NQ; c++) begin lq[r][c] = c_I; lq2[r][c] = c_I; end
         pq[r] = 1'b0; pq2[r] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst_new = 1'b0;
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", out_count, 0);
      chk("rst_index", out_index, 0);
      chk("rst_lit", out_literals, 0);
      chk("rst_last", out_last, 0);
      @(posedge clk); #1;

      load_test_bank();
      readout(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // all four rows
      readout(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);   // identity row 2 dropped
      readout(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);   // empty Q2 bank
      readout(1'b0, 1'b0, 1, 1, 1'b1, 1'b0);   // stall on row 1 while bank changes
      load_test_bank();
      readout(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);   // start pulses ignored while busy

      // reset while row 2 is pending
      load_test_bank();
      start = 1'b1; select_q2 = 1'b0; skip_identity = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pend_idx", out_index, 2);
      rst_new = 1'b1;
      @(posedge clk); #1;
      rst_new = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_count", out_count, 0);
      chk("abort_done", done, 0);
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_no_valid", out_valid, 0);
      end
      @(posedge clk); #1;

      repeat (30) begin
         scramble_banks();
         readout(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 0, 1'b1,
                 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
